// File: rtl/btn_press_classifier.sv
// Classifies debounced button presses into short press, double click and long press,
// with optional auto-repeat pulses while a long press is held.
module btn_press_classifier #(
  parameter int               CNT_W       = 26,
  parameter logic [CNT_W-1:0] LONG_TIME   = 26'd50_000_000,
  parameter logic [CNT_W-1:0] DOUBLE_GAP  = 26'd12_500_000,
  parameter logic [CNT_W-1:0] REPEAT_TIME = 26'd10_000_000,
  parameter logic             REPEAT_EN   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic hold_repeat,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    GAP,
    PRESS2,
    LONG
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = LONG_TIME - 1'b1;
  localparam logic [CNT_W-1:0] GAP_LAST    = DOUBLE_GAP - 1'b1;
  localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_TIME - 1'b1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_prev_q, btn_prev_d;
  logic             short_press_q, short_press_d;
  logic             double_click_q, double_click_d;
  logic             long_press_q, long_press_d;
  logic             hold_repeat_q, hold_repeat_d;
  logic             busy_q, busy_d;
  logic             rise, fall;

  assign rise = btn_level & ~btn_prev_q;
  assign fall = ~btn_level & btn_prev_q;

  // Release/press edges win over the timers when both land on the same cycle.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    btn_prev_d     = btn_level;
    short_press_d  = 1'b0;
    double_click_d = 1'b0;
    long_press_d   = 1'b0;
    hold_repeat_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1: begin
        if (fall) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d      = LONG;
          cnt_d        = '0;
          long_press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (rise) begin
          state_d = PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d       = IDLE;
          cnt_d         = '0;
          short_press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESS2: begin
        cnt_d = '0;
        if (fall) begin
          state_d        = IDLE;
          double_click_d = 1'b1;
        end
      end
      LONG: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d         = '0;
          hold_repeat_d = REPEAT_EN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // btn_prev resets high so a button held through reset needs a fresh press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      btn_prev_q     <= 1'b1;
      short_press_q  <= 1'b0;
      double_click_q <= 1'b0;
      long_press_q   <= 1'b0;
      hold_repeat_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      btn_prev_q     <= btn_prev_d;
      short_press_q  <= short_press_d;
      double_click_q <= double_click_d;
      long_press_q   <= long_press_d;
      hold_repeat_q  <= hold_repeat_d;
      busy_q         <= busy_d;
    end
  end

  assign short_press  = short_press_q;
  assign double_click = double_click_q;
  assign long_press   = long_press_q;
  assign hold_repeat  = hold_repeat_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_btn_press_classifier.sv
// Directed bench for btn_press_classifier: every output is compared every cycle
// against hand-computed pulse positions (edge index counted from the first changed sample).
module tb_btn_press_classifier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic btn_a, btn_b;
  logic sp_a, dc_a, lp_a, hr_a, busy_a;
  logic sp_b, dc_b, lp_b, hr_b, busy_b;

  btn_press_classifier #(
    .LONG_TIME(26'd20), .DOUBLE_GAP(26'd10), .REPEAT_TIME(26'd5), .REPEAT_EN(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_a),
    .short_press(sp_a), .double_click(dc_a), .long_press(lp_a),
    .hold_repeat(hr_a), .busy(busy_a)
  );

  btn_press_classifier #(
    .LONG_TIME(26'd20), .DOUBLE_GAP(26'd10), .REPEAT_TIME(26'd5), .REPEAT_EN(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_b),
    .short_press(sp_b), .double_click(dc_b), .long_press(lp_b),
    .hold_repeat(hr_b), .busy(busy_b)
  );

  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   exp_short, exp_double, exp_long, exp_rep1, exp_rep2, busy_end;
  logic use_b   = 1'b0;

  task automatic checkOutput(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Expected edge index of each pulse (-1 = never); busy is expected high for edges < busy_end.
  task automatic setExpect(input int s, input int d, input int l,
                           input int r1, input int r2, input int b);
    exp_short  = s;
    exp_double = d;
    exp_long   = l;
    exp_rep1   = r1;
    exp_rep2   = r2;
    busy_end   = b;
    cyc        = 0;
  endtask

  task automatic applyStimulus(input logic lvl, input logic rst_v, input int n);
    for (int i = 0; i < n; i++) begin
      if (use_b) btn_b = lvl;
      else       btn_a = lvl;
      rst_n = rst_v;
      @(posedge clk);
      #1;
      checkOutput("short_press",  int'(use_b ? sp_b : sp_a),     int'(cyc == exp_short));
      checkOutput("double_click", int'(use_b ? dc_b : dc_a),     int'(cyc == exp_double));
      checkOutput("long_press",   int'(use_b ? lp_b : lp_a),     int'(cyc == exp_long));
      checkOutput("hold_repeat",  int'(use_b ? hr_b : hr_a),
                  int'(cyc == exp_rep1 || cyc == exp_rep2));
      checkOutput("busy",         int'(use_b ? busy_b : busy_a), int'(cyc < busy_end));
      cyc++;
    end
  endtask

  initial begin
    btn_a = 1'b0;
    btn_b = 1'b0;
    rst_n = 1'b0;

    $display("[TB] reset state");
    setExpect(-1, -1, -1, -1, -1, 0);
    applyStimulus(1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b1, 3);

    $display("[TB] short press");
    setExpect(15, -1, -1, -1, -1, 15);
    applyStimulus(1'b1, 1'b1, 5);
    applyStimulus(1'b0, 1'b1, 20);

    $display("[TB] double click");
    setExpect(-1, 10, -1, -1, -1, 10);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 4);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 20);

    $display("[TB] long hold with repeat");
    setExpect(-1, -1, 20, 25, 30, 32);
    applyStimulus(1'b1, 1'b1, 32);
    applyStimulus(1'b0, 1'b1, 10);

    $display("[TB] second rise on last gap cycle");
    setExpect(-1, 14, -1, -1, -1, 14);
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 20);

    $display("[TB] release on last press1 cycle");
    setExpect(30, -1, -1, -1, -1, 30);
    applyStimulus(1'b1, 1'b1, 20);
    applyStimulus(1'b0, 1'b1, 20);

    $display("[TB] reset during long hold");
    setExpect(-1, -1, 20, -1, -1, 23);
    applyStimulus(1'b1, 1'b1, 23);
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b1, 1'b1, 5);
    applyStimulus(1'b0, 1'b1, 5);
    setExpect(15, -1, -1, -1, -1, 15);
    applyStimulus(1'b1, 1'b1, 5);
    applyStimulus(1'b0, 1'b1, 20);

    $display("[TB] long hold with repeat disabled");
    use_b = 1'b1;
    setExpect(-1, -1, 20, -1, -1, 32);
    applyStimulus(1'b1, 1'b1, 32);
    applyStimulus(1'b0, 1'b1, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
